// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, types, byte indexing and S-box tables
package aes_pkg;

    localparam int NB     = 4;
    localparam int BYTE_W = 8;

    typedef logic [NB*NB*BYTE_W-1:0] state_t;

    typedef enum logic {
        IDLE,
        RUN
    } fsm_t;

    function automatic int idx(input int r, input int c);
        return 4 * c + r;
    endfunction

    // Byte k sits MSB-first: byte 0 occupies [127:120].
    function automatic logic [BYTE_W-1:0] get_byte(input state_t s, input int k);
        return s[BYTE_W*(NB*NB-1-k) +: BYTE_W];
    endfunction

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box lookup, inverse or forward (AES_FWD_PATH_EN)
module aes_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              inv,
    output logic [BYTE_W-1:0] out_byte
);

`ifdef AES_FWD_PATH_EN
    assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];
`else
    // Inverse-only build: the flag has no effect and the forward table is never referenced.
    logic unused_inv;
    assign unused_inv = inv;
    assign out_byte   = INV_SBOX[in_byte];
`endif

endmodule

// File: rtl/inv_subshift.sv
// rtl/inv_subshift.sv - InvShiftRows+InvSubBytes, one column per clock; AES_FWD_PATH_EN adds the forward path
module inv_subshift
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] data_i,
`ifdef AES_FWD_PATH_EN
    input  logic         decrypt_i,
`endif
    output logic [127:0] data_o,
    output logic         ready_o,
    output logic         busy_o
);

    fsm_t              fsm_q, fsm_d;
    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [31:0]       col_q [NB];
    logic              load, wr_col, done;
    logic              dec_q;
    logic [BYTE_W-1:0] sb_in  [NB];
    logic [BYTE_W-1:0] sb_out [NB];
    logic [31:0]       col_w;

    // Row r of output column cnt reads the source column rotated by r.
    for (genvar r = 0; r < NB; r++) begin : g_row
        logic [1:0] c_src;
`ifdef AES_FWD_PATH_EN
        assign c_src = dec_q ? cnt_q - 2'(r) : cnt_q + 2'(r);
`else
        assign c_src = cnt_q - 2'(r);
`endif
        assign sb_in[r] = get_byte(state_q, idx(r, int'(c_src)));

        aes_sbox u_sbox (
            .in_byte  (sb_in[r]),
            .inv      (dec_q),
            .out_byte (sb_out[r])
        );
    end

    assign col_w  = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
    assign data_o = {col_q[0], col_q[1], col_q[2], col_q[3]};

    always_comb begin
        fsm_d  = fsm_q;
        load   = 1'b0;
        wr_col = 1'b0;
        done   = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    load  = 1'b1;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                wr_col = 1'b1;
                if (cnt_q == 2'd3) begin
                    done  = 1'b1;
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= 2'd0;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
            for (int c = 0; c < NB; c++) col_q[c] <= '0;
        end else begin
            fsm_q   <= fsm_d;
            ready_o <= done;
            if (load) begin
                state_q <= data_i;
                cnt_q   <= 2'd0;
                busy_o  <= 1'b1;
            end
            if (wr_col) begin
                col_q[cnt_q] <= col_w;
                cnt_q        <= cnt_q + 2'd1;
            end
            if (done) busy_o <= 1'b0;
        end
    end

`ifdef AES_FWD_PATH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    dec_q <= 1'b1;
        else if (load) dec_q <= decrypt_i;
    end
`else
    assign dec_q = 1'b1;
`endif

endmodule

// File: tb/tb_inv_subshift.sv
// tb/tb_inv_subshift.sv - self-checking bench for inv_subshift with GF(2^8)-derived S-box model
module tb_inv_subshift;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] data_i = '0;
    logic         tb_dec = 1'b1;
    logic [127:0] data_o;
    logic         ready_o, busy_o;

    int total = 0;
    int bad = 0;
    int ready_cnt = 0;
    int cyc = 0;
    int acc_q[$];

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    bit           m_busy, m_ready, m_dec;
    int           m_age;
    logic [127:0] m_res, m_out;

    inv_subshift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .data_i    (data_i),
`ifdef AES_FWD_PATH_EN
        .decrypt_i (tb_dec),
`endif
        .data_o    (data_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] d, input int k);
        logic [127:0] t;
        t = d >> (8 * (15 - k));
        return t[7:0];
    endfunction

    // Whole-block reference: shift rows by row index, then substitute every byte.
    function automatic logic [127:0] xform(input logic [127:0] d, input bit dec);
        logic [127:0] o;
        logic [7:0]   b;
        int           src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = dec ? (c - r + 4) % 4 : (c + r) % 4;
                b   = byte_of(d, 4 * src + r);
                b   = dec ? inv_t[b] : fwd_t[b];
                o   = o | (128'(b) << (8 * (15 - (4 * c + r))));
            end
        end
        return o;
    endfunction

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_ready = 1'b0;
        m_age   = 0;
        m_out   = '0;
        m_res   = '0;
    endfunction

    initial begin
        logic [7:0] inv_e, b;
        for (int a = 0; a < 256; a++) begin
            inv_e = 8'h01;
            for (int i = 0; i < 254; i++) inv_e = gmul(inv_e, 8'(a));
            b = inv_e ^ rotl(inv_e, 1) ^ rotl(inv_e, 2) ^ rotl(inv_e, 3) ^ rotl(inv_e, 4) ^ 8'h63;
            fwd_t[a] = b;
            inv_t[b] = 8'(a);
        end
        model_reset();
    end

    always begin
        logic [127:0] mask;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_ready = 1'b0;
            if (m_busy) begin
                mask  = 128'hffffffff << (32 * (3 - m_age));
                m_out = (m_out & ~mask) | (m_res & mask);
                m_age++;
                if (m_age == 4) begin
                    m_busy  = 1'b0;
                    m_ready = 1'b1;
                end
            end else if (start_i) begin
`ifdef AES_FWD_PATH_EN
                m_dec = tb_dec;
`else
                m_dec = 1'b1;
`endif
                m_res  = xform(data_i, m_dec);
                m_busy = 1'b1;
                m_age  = 0;
                acc_q.push_back(cyc);
            end
        end
        @(negedge clk);
        if (!rst_n) model_reset();
        check("busy", 128'(busy_o), 128'(m_busy));
        check("ready", 128'(ready_o), 128'(m_ready));
        check("data_o", data_o, m_out);
        if (ready_o) ready_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_block(input logic [127:0] d);
        start_i = 1'b1;
        data_i  = d;
        step();
        start_i = 1'b0;
        data_i  = ~d;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ready_o && n < 20);
    endtask

    initial begin
        int n, r0;

        check("pin_sbox_00", 128'(fwd_t[8'h00]), 128'h63);
        check("pin_sbox_01", 128'(fwd_t[8'h01]), 128'h7c);
        check("pin_inv_00", 128'(inv_t[8'h00]), 128'h52);
        check("pin_inv_63", 128'(inv_t[8'h63]), 128'h00);

        repeat (3) step();
        check("rst_data_o", data_o, '0);
        check("rst_ready", 128'(ready_o), 128'h0);
        check("rst_busy", 128'(busy_o), 128'h0);
        rst_n = 1'b1;
        repeat (10) step();
        check("idle_no_ready", 128'(ready_cnt), 128'h0);

        start_block('0);
        wait_ready(n);
        check("latency", 128'(n), 128'd4);
        check("all_zero", data_o, {16{8'h52}});
        step();

        start_block({8'h63, 8'h7c, {14{8'h63}}});
        wait_ready(n);
        check("shift_row1", data_o, 128'h00000000_00010000_00000000_00000000);
        step();

        acc_q.delete();
        r0 = ready_cnt;
        start_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data_i = 128'h00112233_44556677_8899aabb_ccddeeff ^ {16{8'(i * 37 + 5)}};
            step();
        end
        start_i = 1'b0;
        repeat (8) step();
        check("b2b_accepts", 128'(acc_q.size()), 128'd3);
        if (acc_q.size() == 3) begin
            check("b2b_gap1", 128'(acc_q[1] - acc_q[0]), 128'd5);
            check("b2b_gap2", 128'(acc_q[2] - acc_q[0]), 128'd10);
        end
        check("b2b_ready", 128'(ready_cnt - r0), 128'd3);

        start_block(128'h0123456789abcdeffedcba9876543210);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check("abort_data_o", data_o, '0);
        check("abort_busy", 128'(busy_o), 128'h0);
        check("abort_ready", 128'(ready_o), 128'h0);
        r0 = ready_cnt;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        check("abort_no_ready", 128'(ready_cnt - r0), 128'h0);
        start_block('0);
        wait_ready(n);
        check("post_abort_latency", 128'(n), 128'd4);
        check("post_abort_data", data_o, {16{8'h52}});
        step();

`ifdef AES_FWD_PATH_EN
        tb_dec = 1'b0;
        start_block(128'h00000000_00010000_00000000_00000000);
        wait_ready(n);
        check("fwd_result", data_o, 128'h637c6363_63636363_63636363_63636363);
        step();
        tb_dec = 1'b1;
        start_block(128'h637c6363_63636363_63636363_63636363);
        wait_ready(n);
        check("inv_roundtrip", data_o, 128'h00000000_00010000_00000000_00000000);
        step();
`endif

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
